// File: rtl/scanout_fetcher.sv
// scanout_fetcher: streams the frame buffer out in raster order into a small
// credit-limited FIFO that the VGA side pops one pixel per strobe.
`default_nettype none

module scanout_fetcher #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 24
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               pix_req,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_valid,
  output logic               underflow,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [COLOR_W-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      discard_q, discard_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               underflow_q, underflow_d;
  logic [COLOR_W-1:0] fifo_q [DEPTH];

  logic [SW-1:0]      credit_sum;
  logic               accept;
  logic               last_px;
  logic               fifo_wr;
  logic               fifo_pop;

  // Outstanding reads reserve FIFO slots, so the FIFO can never overflow.
  assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
  assign mem_rd     = (state_q == S_FETCH) && (credit_sum < SW'(DEPTH));
  assign accept     = mem_rd && mem_ready;
  assign last_px    = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));
  assign fifo_wr    = mem_rvalid && (discard_q == '0) && !frame_start;
  assign fifo_pop   = pix_req && (count_q != '0);

  assign mem_addr   = addr_q;
  assign pix_valid  = (count_q != '0);
  assign pix_color  = pix_valid ? fifo_q[rd_ptr_q] : '0;
  assign underflow  = underflow_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    discard_d   = discard_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underflow_d = underflow_q;

    unique case ({accept, mem_rvalid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (frame_start) begin
      // Everything still outstanding, including this cycle's accept, is stale.
      state_d     = S_FETCH;
      x_d         = '0;
      y_d         = '0;
      addr_d      = '0;
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      underflow_d = 1'b0;
      discard_d   = inflight_d;
    end else begin
      if (state_q == S_FETCH && accept) begin
        if (last_px) begin
          state_d = S_DONE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_q == XW'(H_RES - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      if (mem_rvalid && discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end
      wr_ptr_d = wr_ptr_q + PW'(fifo_wr);
      rd_ptr_d = rd_ptr_q + PW'(fifo_pop);
      count_d  = count_q + CW'(fifo_wr) - CW'(fifo_pop);
      if (pix_req && count_q == '0) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      discard_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (fifo_wr) begin
      fifo_q[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scanout_fetcher.sv
// tb_scanout_fetcher: randomized bench comparing scanout_fetcher against a
// transaction-level model of the frame, the read port and the pixel FIFO.
`default_nettype none

module tb_scanout_fetcher;

  localparam int H  = 4;
  localparam int V  = 5;
  localparam int N  = H * V;
  localparam int D  = 16;
  localparam int AW = 8;
  localparam int CW = 24;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_start;
  logic          pix_req;
  logic [CW-1:0] pix_color;
  logic          pix_valid;
  logic          underflow;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [CW-1:0] mem_rdata;

  scanout_fetcher #(
    .H_RES(H), .V_RES(V), .DEPTH(D), .ADDR_W(AW), .COLOR_W(CW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_req(pix_req),
    .pix_color(pix_color), .pix_valid(pix_valid), .underflow(underflow),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned tag;
    int unsigned addr;
    longint      due;
  } req_t;

  req_t          pend[$];
  logic [CW-1:0] fifo_m[$];

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cur_frame = 0;
  int     next_addr = 0;
  int     pop_idx   = 0;
  int     n_acc     = 0;
  bit     fetching  = 0;
  bit     uf_m      = 0;
  longint cyc       = 0;
  longint last_due  = 0;
  int     lat       = 3;
  bit     rand_lat  = 0;
  int     ready_mode = 0;
  int     req_mode   = 0;
  bit     stalled_prev = 0;
  int     held_addr    = 0;
  bit     got_first    = 0;
  logic [CW-1:0] first_pop = '0;

  // Pixel payload identifies its frame so stale data cannot pass as fresh.
  function automatic logic [CW-1:0] pix_data(input int unsigned fr, input int unsigned a);
    return {8'(fr), 16'(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input bit fs);
    bit   acc, rv, pr, nonempty;
    int   a;
    req_t r;
    longint due;
    frame_start = fs;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = 1'($urandom_range(0, 1));
      default: mem_ready = 1'b0;
    endcase
    case (req_mode)
      0:       pix_req = 1'b0;
      1:       pix_req = 1'b1;
      2:       pix_req = 1'($urandom_range(0, 1));
      default: pix_req = (pop_idx < N);
    endcase
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pix_data(pend[0].tag, pend[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = CW'($urandom);
    end
    #1;
    chk("pix_valid", 32'(pix_valid), 32'(fifo_m.size() != 0));
    chk("pix_color", 32'(pix_color), (fifo_m.size() != 0) ? 32'(fifo_m[0]) : 32'd0);
    chk("underflow", 32'(underflow), 32'(uf_m));
    chk("mem_rd", 32'(mem_rd), 32'(fetching && (fifo_m.size() + pend.size() < D)));
    if (mem_rd) chk("mem_addr", 32'(mem_addr), 32'(next_addr));
    if (mem_rd && stalled_prev) chk("addr_hold", 32'(mem_addr), 32'(held_addr));
    if (pix_req && fifo_m.size() != 0) begin
      chk("pop_order", 32'(pix_color), 32'(pix_data(cur_frame, pop_idx)));
      if (pop_idx == 0 && !got_first) begin
        got_first = 1;
        first_pop = pix_color;
      end
    end
    acc = mem_rd && mem_ready;
    a   = int'(mem_addr);
    rv  = mem_rvalid;
    pr  = pix_req;
    nonempty = (fifo_m.size() != 0);
    stalled_prev = mem_rd && !mem_ready && !fs;
    held_addr    = a;

    @(posedge Clk);
    if (rv) r = pend.pop_front();
    if (pr && nonempty) begin
      void'(fifo_m.pop_front());
      pop_idx++;
    end
    if (rv && !fs && r.tag == cur_frame) fifo_m.push_back(pix_data(r.tag, r.addr));
    if (acc) begin
      due = cyc + lat + (rand_lat ? longint'($urandom_range(0, 3)) : 0);
      if (due < last_due) due = last_due;
      last_due = due;
      pend.push_back('{tag: cur_frame, addr: a, due: due});
    end
    if (fs) uf_m = 0;
    else if (pr && !nonempty) uf_m = 1;
    if (fs) begin
      cur_frame++;
      fifo_m.delete();
      next_addr = 0;
      pop_idx   = 0;
      n_acc     = 0;
      fetching  = 1;
      got_first = 0;
    end else if (acc) begin
      next_addr++;
      n_acc++;
      if (next_addr == N) fetching = 0;
    end
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with junk on every input.
    Reset_n     = 1'b0;
    frame_start = 1'b1;
    pix_req     = 1'b1;
    mem_ready   = 1'b1;
    mem_rvalid  = 1'b1;
    mem_rdata   = CW'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      #1;
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_color", 32'(pix_color), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
    end
    Reset_n = 1'b1;
    repeat (3) cycle(0);

    // Fill until credits run out.
    lat = 3;
    cycle(1);
    repeat (40) cycle(0);
    chk("t2_reqs", 32'(n_acc), 32'd16);
    chk("t2_valid", 32'(pix_valid), 32'd1);
    chk("t2_head", 32'(pix_color), 32'(pix_data(cur_frame, 0)));

    // Whole frame with raster wrap, continuous popping.
    cycle(1);
    for (int i = 0; i < 50 && !pix_valid; i++) cycle(0);
    chk("t3_wait", 32'(pix_valid), 32'd1);
    repeat (5) cycle(0);
    req_mode = 3;
    repeat (80) cycle(0);
    chk("t3_pops", 32'(pop_idx), 32'(N));
    chk("t3_reqs", 32'(n_acc), 32'(N));
    chk("t3_uf", 32'(underflow), 32'd0);

    // Random backpressure, random popping, jittered latency.
    ready_mode = 1;
    req_mode   = 2;
    rand_lat   = 1;
    lat        = 2;
    cycle(1);
    repeat (150) cycle(0);
    ready_mode = 0;
    repeat (60) cycle(0);
    chk("t4_reqs", 32'(n_acc), 32'(N));

    // Long latency with the consumer pulling from the start.
    rand_lat = 0;
    lat      = 20;
    req_mode = 1;
    cycle(1);
    repeat (15) cycle(0);
    chk("t5_uf_early", 32'(underflow), 32'd1);
    chk("t5_color0", 32'(pix_color), 32'd0);
    repeat (60) cycle(0);
    chk("t5_uf_sticky", 32'(underflow), 32'd1);
    chk("t5_got_data", 32'(pop_idx > 0), 32'd1);

    // Restart mid-frame with exactly five reads outstanding.
    req_mode = 0;
    lat      = 10;
    cycle(1);
    chk("t6_uf_clear", 32'(underflow), 32'd0);
    for (int i = 0; i < 20 && pend.size() < 5; i++) cycle(0);
    chk("t6_inflight", 32'(pend.size()), 32'd5);
    ready_mode = 2;
    cycle(1);
    ready_mode = 0;
    req_mode   = 2;
    repeat (120) cycle(0);
    chk("t6_popped", 32'(got_first), 32'd1);
    chk("t6_first", 32'(first_pop), 32'(pix_data(cur_frame, 0)));
    chk("t6_reqs", 32'(n_acc), 32'(N));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
